// File: rtl/mips_cpu_instr_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared constants, state encoding and byte-swap helper for the
//               MIPS instruction-side memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_t;

    function automatic logic [31:0] byteswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_instr_memory_loader.sv
`default_nettype none
// ============================================================================
// Module      : mips_instr_loader
// Description : Program loader FSM: accepts the valid/ready word stream,
//               produces the array write strobe/address and the CPU enable.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_instr_loader
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic          load_last,
    output logic          load_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          run,
    output logic          cpu_clk_enable
);

    imem_state_t   state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          cpu_en_q, cpu_en_d;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_en      = 1'b0;
        // A restart pulse wins over any word presented in the same cycle.
        load_ready = (state_q == LOAD) && !load_start;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    wr_ptr_d = '0;
                end else if (load_valid && load_ready) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (load_last || (wr_ptr_q == AW'(DEPTH_WORDS - 1))) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Rises one cycle after entering RUN, drops on the edge that leaves it.
        cpu_en_d = (state_q == RUN) && (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            cpu_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cpu_en_q <= cpu_en_d;
        end
    end

    assign wr_addr        = wr_ptr_q;
    assign run            = (state_q == RUN);
    assign cpu_clk_enable = cpu_en_q;

endmodule
`default_nettype wire

// File: rtl/mips_cpu_instr_memory.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_instr_memory
// Description : Instruction memory for mips_cpu_harvard: zero-wait fetch port,
//               stream-loaded program array, sticky address fault flag.
//               Optional fetch counter enabled by macro FETCH_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_instr_memory
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        cpu_clk_enable,
    input  logic        load_start,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        addr_fault,
    output logic [31:0] fetch_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          run;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   offset;
    logic          in_range;
    logic          aligned;
    logic          is_halt;
    logic          fetch_bad;
    logic          fault_q, fault_d;

    mips_instr_loader #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_loader (
        .clk            (clk),
        .reset          (reset),
        .load_start     (load_start),
        .load_valid     (load_valid),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .run            (run),
        .cpu_clk_enable (cpu_clk_enable)
    );

    // Array contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= load_data;
        end
    end

    // BASE_ADDR is word aligned, so the offset's low bits give the alignment.
    always_comb begin
        offset         = instr_address - BASE_ADDR;
        in_range       = (offset[31:AW+2] == '0);
        aligned        = (offset[1:0] == 2'b00);
        is_halt        = (instr_address == HALT_ADDR);
        fetch_bad      = !is_halt && !(in_range && aligned);
        instr_readdata = NOP_WORD;
        if (!is_halt && in_range && aligned) begin
            instr_readdata = byteswap32(mem_q[offset[AW+1:2]]);
        end
    end

    always_comb begin
        fault_d = fault_q;
        if (load_start) begin
            fault_d = 1'b0;
        end else if (run && cpu_clk_enable && fetch_bad) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign addr_fault = fault_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (load_start) begin
            fetch_count_d = '0;
        end else if (run && cpu_clk_enable && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 32'h0;
`endif

endmodule
`default_nettype wire
